dwt_sched: RTL and testbench
============================

Name: dwt_sched

Overview:
- Sequencer for the shared 4-tap low/high wavelet filter pair in a multi-level 1-D DWT.
- Reads a line from an external single-port sample memory and feeds it to the filter pair one sample at a time.
- Downsamples by 2 and writes each approximation coefficient back in place for the next level.
- Streams detail coefficients out on a valid/ready interface.

Parameters:
- DW, 16: sample / coefficient width.
- AW, 10: memory address width; maximum line length is 2^AW.
- MAX_LVL, 4: maximum decomposition levels.
- LW, 3: width of level fields; must satisfy 2^LW > MAX_LVL.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_len  in  AW+1  level-0 line length; even, 2..2^AW
- cfg_lvls  in  LW  requested levels, 0..MAX_LVL
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job ends
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DW  approximation write data
- mem_rdata  in  DW  read data, valid 1 cycle after address
- filt_din  out  DW  sample to the filter taps
- filt_en  out  1  tap shift enable
- filt_clr  out  1  synchronous clear of all taps
- filt_lo  in  DW  low-pass output, combinational from taps
- filt_hi  in  DW  high-pass output, combinational from taps
- det_data  out  DW  detail coefficient
- det_lvl  out  LW  level of det_data, 0-based
- det_valid  out  1  detail valid
- det_ready  in  1  sink ready

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - All outputs and internal counters go to 0.
  - A job in progress is abandoned; there is no resume.
- States: IDLE, CLR, RD, FEED, CAP, OUT, DONE.
- IDLE:
  - On start, latch cfg_len into n and cfg_lvls into lv; set lvl=0, i=0.
  - If lv==0, go to DONE; otherwise go to CLR.
  - start in any other state is ignored.
- CLR:
  - filt_clr=1 for one cycle (zero-pads the leading taps).
  - Then go to RD.
- RD: mem_addr=i, mem_we=0; go to FEED.
- FEED:
  - filt_din=mem_rdata, filt_en=1.
  - If i is odd, go to CAP; else i++ and go to RD.
- CAP:
  - mem_we=1, mem_addr=i>>1, mem_wdata=filt_lo.
  - Register det_data<=filt_hi and det_lvl<=lvl.
  - Go to OUT.
- OUT:
  - det_valid=1; det_data and det_lvl are held stable.
  - On det_valid&&det_ready, handle the end of the sample:
    - If i==n-1, go to level end.
    - Else i++ and go to RD.
  - A stall while det_ready is low freezes everything: filt_en=0, no memory access.
- Level end:
  - lvl++, n=n>>1, i=0.
  - If lvl==lv or n<2, go to DONE; else go to CLR.
- DONE: done=1 for one cycle, then go to IDLE.
- In-place safety: the write address (i>>1) is always below the next read address (i+1); no hazard.
- Timing per level of length N with det_ready held high: 1 + 3N cycles.
  - Even sample: 2 cycles (RD, FEED).
  - Odd sample: 4 cycles (RD, FEED, CAP, OUT).
- Arithmetic: no arithmetic on coefficients. Address and length counters are AW+1 bits; odd n after shifting is not supported (caller guarantees cfg_len is a multiple of 2^cfg_lvls).

Decomposition:
- Shared package dwt_pkg holds:
  - FSM state enum.
  - DW, AW, MAX_LVL, LW defaults.
  - Level-length helper function (n>>lvl).
- One natural sub-module: dwt_lvl_cnt, holding the level, length and index counters with their end-of-level and end-of-job compares.
- The FSM stays in dwt_sched.

Test Plan:
Bench filter stub: filt_lo = newest tap, filt_hi = oldest tap. Memory preloaded with x[i]=i+1. det_ready=1 unless stated.
- cfg_len=8, cfg_lvls=1 -> memory addresses 0..3 become 2,4,6,8; details 0,1,3,5 with det_lvl=0; done pulses 25 cycles after CLR entry; busy falls with done.
- cfg_len=8, cfg_lvls=2 -> level 0 as above; then details 0,2 with det_lvl=1; memory addresses 0,1 become 4,8; exactly one done pulse.
- cfg_len=8, cfg_lvls=1, det_ready low for 5 cycles at the first OUT -> det_valid held with det_data=0 stable; filt_en=0 and mem_we=0 during the stall; final results identical, done delayed by 5 cycles.
- cfg_len=4, cfg_lvls=3 -> level-2 length is 1, so the job stops after 2 levels: 2+1 details, one done pulse. cfg_lvls=0 -> done asserted 1 cycle after start with no memory access.
- rst pulsed mid-level -> all outputs 0 immediately; the next start runs the full job correctly. start pulsed while busy -> ignored, results unchanged.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared types and defaults for the multi-level 1-D DWT sequencer.
// The level-length helper keeps the "length at level L" rule in one place.
package dwt_pkg;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 10;
  localparam int DEF_MAX_LVL = 4;
  localparam int DEF_LW      = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_FEED,
    S_CAP,
    S_OUT,
    S_DONE
  } state_t;

  function automatic int unsigned lvl_len(input int unsigned len0, input int unsigned lvl);
    return len0 >> lvl;
  endfunction

endpackage

// File: rtl/dwt_lvl_cnt.sv
// Level, line-length and sample-index counters of the DWT sequencer,
// with the end-of-line and end-of-job compares the FSM branches on.
module dwt_lvl_cnt
  import dwt_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int LW      = DEF_LW,
  parameter int MAX_LVL = DEF_MAX_LVL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW:0]   cfg_len,
  input  logic [LW-1:0] cfg_lvls,
  input  logic          inc_i,
  input  logic          lvl_end,
  output logic [AW:0]   idx,
  output logic [LW-1:0] lvl,
  output logic          idx_odd,
  output logic          idx_last,
  output logic          job_end
);

  logic [AW:0]   len0;
  logic [LW-1:0] lv;
  logic [LW-1:0] lvl_next;
  logic [AW:0]   len_cur;
  logic [AW:0]   len_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len0 <= '0;
      lv   <= '0;
      lvl  <= '0;
      idx  <= '0;
    end else if (load) begin
      len0 <= cfg_len;
      lv   <= (cfg_lvls > LW'(MAX_LVL)) ? LW'(MAX_LVL) : cfg_lvls;
      lvl  <= '0;
      idx  <= '0;
    end else if (lvl_end) begin
      lvl <= lvl_next;
      idx <= '0;
    end else if (inc_i) begin
      idx <= idx + (AW+1)'(1);
    end
  end

  // The current length is derived from the latched level-0 length, so halving
  // per level needs no separate register.
  always_comb begin
    lvl_next = lvl + LW'(1);
    len_cur  = (AW+1)'(lvl_len(32'(len0), 32'(lvl)));
    len_next = (AW+1)'(lvl_len(32'(len0), 32'(lvl_next)));
  end

  assign idx_odd  = idx[0];
  assign idx_last = (idx == len_cur - (AW+1)'(1));
  assign job_end  = (lvl_next == lv) || (len_next < (AW+1)'(2));

endmodule

// File: rtl/dwt_sched.sv
// Sequencer feeding a shared 4-tap low/high filter pair from a single-port
// line memory, writing approximations back in place and streaming details.
module dwt_sched
  import dwt_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int MAX_LVL = DEF_MAX_LVL,
  parameter int LW      = DEF_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   cfg_len,
  input  logic [LW-1:0] cfg_lvls,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] filt_din,
  output logic          filt_en,
  output logic          filt_clr,
  input  logic [DW-1:0] filt_lo,
  input  logic [DW-1:0] filt_hi,
  output logic [DW-1:0] det_data,
  output logic [LW-1:0] det_lvl,
  output logic          det_valid,
  input  logic          det_ready
);

  state_t        state;
  state_t        state_next;
  logic          load;
  logic          inc_i;
  logic          lvl_end;
  logic [AW:0]   idx;
  logic [LW-1:0] lvl;
  logic          idx_odd;
  logic          idx_last;
  logic          job_end;

  dwt_lvl_cnt #(
    .AW      (AW),
    .LW      (LW),
    .MAX_LVL (MAX_LVL)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .cfg_len  (cfg_len),
    .cfg_lvls (cfg_lvls),
    .inc_i    (inc_i),
    .lvl_end  (lvl_end),
    .idx      (idx),
    .lvl      (lvl),
    .idx_odd  (idx_odd),
    .idx_last (idx_last),
    .job_end  (job_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (cfg_lvls == '0) ? S_DONE : S_CLR;
      S_CLR:   state_next = S_RD;
      S_RD:    state_next = S_FEED;
      S_FEED:  state_next = idx_odd ? S_CAP : S_RD;
      S_CAP:   state_next = S_OUT;
      S_OUT: begin
        // Level end is folded into the accepting OUT cycle: next is CLR or DONE.
        if (det_ready) begin
          if (!idx_last)    state_next = S_RD;
          else if (job_end) state_next = S_DONE;
          else              state_next = S_CLR;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: every output gets a value on every path of this block, otherwise
  // synthesis infers a latch to hold the previous value.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    filt_clr  = (state == S_CLR);
    filt_en   = (state == S_FEED);
    filt_din  = (state == S_FEED) ? mem_rdata : '0;
    mem_we    = (state == S_CAP);
    mem_wdata = (state == S_CAP) ? filt_lo : '0;
    det_valid = (state == S_OUT);
    mem_addr  = '0;
    if (state == S_RD)  mem_addr = idx[AW-1:0];
    if (state == S_CAP) mem_addr = idx[AW:1];
    load      = (state == S_IDLE) && start;
    inc_i     = ((state == S_FEED) && !idx_odd) ||
                ((state == S_OUT) && det_ready && !idx_last);
    lvl_end   = (state == S_OUT) && det_ready && idx_last;
  end

  // Detail register stays frozen across OUT stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_data <= '0;
      det_lvl  <= '0;
    end else if (state == S_CAP) begin
      det_data <= filt_hi;
      det_lvl  <= lvl;
    end
  end

endmodule

// File: tb/tb_dwt_sched.sv
// Self-checking bench for dwt_sched: memory and filter stubs around the DUT,
// a per-level arithmetic reference model, directed and randomized jobs.
module tb_dwt_sched;
  import dwt_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int LW  = 3;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   cfg_len;
  logic [LW-1:0] cfg_lvls;
  logic          busy, done, mem_we, filt_en, filt_clr, det_valid, det_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, filt_din, filt_lo, filt_hi, det_data;
  logic [LW-1:0] det_lvl;

  logic [DW-1:0] mem      [MEM];
  logic [DW-1:0] init_mem [MEM];
  logic [DW-1:0] exp_mem  [MEM];
  logic          mem_init;
  logic [DW-1:0] tap [4];
  logic [31:0]   exp_det [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dwt_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_lvls(cfg_lvls),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .filt_din(filt_din),
    .filt_en(filt_en), .filt_clr(filt_clr), .filt_lo(filt_lo), .filt_hi(filt_hi),
    .det_data(det_data), .det_lvl(det_lvl), .det_valid(det_valid), .det_ready(det_ready)
  );

  // Single-port memory with one-cycle read latency, and the 4-tap filter stub.
  always @(posedge clk) begin
    if (mem_init) for (int k = 0; k < MEM; k++) mem[k] <= init_mem[k];
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (filt_clr) for (int k = 0; k < 4; k++) tap[k] <= '0;
    else if (filt_en) begin
      tap[0] <= filt_din;
      for (int k = 1; k < 4; k++) tap[k] <= tap[k-1];
    end
  end
  assign filt_lo = tap[0];
  assign filt_hi = tap[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [LW-1:0] l, input logic [DW-1:0] d);
    return {13'b0, l, d};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " ctrl"}, {26'b0, busy, done, mem_we, filt_en, filt_clr, det_valid}, 32'h0);
    check({tag, " addr"}, 32'(mem_addr), 32'h0);
    check({tag, " data"}, {mem_wdata, filt_din}, 32'h0);
    check({tag, " det"}, pack(det_lvl, det_data), 32'h0);
  endtask

  task automatic preload(input bit rnd);
    for (int k = 0; k < MEM; k++) init_mem[k] = rnd ? DW'($urandom) : DW'(k + 1);
    @(negedge clk) mem_init = 1'b1;
    @(negedge clk) mem_init = 1'b0;
  endtask

  // Reference: each level halves the line; odd sample k writes src[k] to k/2
  // and emits the sample three positions older (zero before the line start).
  task automatic build_model(input int len, input int lvls, output int exp_cyc);
    int n;
    int l;
    logic [DW-1:0] src [$];
    exp_det.delete();
    for (int k = 0; k < MEM; k++) exp_mem[k] = init_mem[k];
    exp_cyc = 0;
    if (lvls == 0) return;
    n = len;
    l = 0;
    do begin
      src.delete();
      for (int k = 0; k < n; k++) src.push_back(exp_mem[k]);
      for (int k = 1; k < n; k += 2) begin
        exp_mem[k/2] = src[k];
        exp_det.push_back(pack(LW'(l), (k >= 3) ? src[k-3] : '0));
      end
      exp_cyc += 1 + 3 * n;
      l++;
      n = n / 2;
    end while (l < lvls && n >= 2);
  endtask

  // stall_mode: 0 none, 1 stall_n cycles at the first OUT, 2 random stalls.
  task automatic run_job(input string name, input int len, input int lvls,
                         input int stall_mode, input int stall_n, input int start_again);
    int exp_cyc, done_cyc, done_cnt, stall_cyc, stall_left, bad_stall, we_cnt, en_cnt;
    logic busy_at_done, busy_after, prev_stall;
    logic [DW-1:0] held;
    logic [31:0] got [$];
    build_model(len, lvls, exp_cyc);
    done_cyc = -1; done_cnt = 0; stall_cyc = 0; bad_stall = 0; we_cnt = 0; en_cnt = 0;
    stall_left = (stall_mode == 1) ? stall_n : 0;
    busy_at_done = 1'b0; busy_after = 1'b1; prev_stall = 1'b0; held = '0;
    @(negedge clk);
    cfg_len = (AW+1)'(len);
    cfg_lvls = LW'(lvls);
    start = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = (c == start_again);
      if (c == 0) begin
        cfg_len = (AW+1)'($urandom);
        cfg_lvls = LW'($urandom);
      end
      if (det_valid && stall_mode == 1 && stall_left > 0) begin
        det_ready = 1'b0;
        stall_left--;
      end else if (det_valid && stall_mode == 2 && $urandom_range(3) == 0) begin
        det_ready = 1'b0;
      end else begin
        det_ready = 1'b1;
      end
      if (det_valid && !det_ready) begin
        stall_cyc++;
        if (filt_en || mem_we) bad_stall++;
      end
      if (prev_stall && det_data !== held) bad_stall++;
      prev_stall = det_valid && !det_ready;
      held = det_data;
      if (det_valid && det_ready) got.push_back(pack(det_lvl, det_data));
      if (mem_we) we_cnt++;
      if (filt_en) en_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && c == done_cyc + 3) break;
    end
    start = 1'b0;
    det_ready = 1'b1;
    if (done_cyc < 0) begin
      check({name, " timeout"}, 32'h0, 32'h1);
    end else begin
      check({name, " done cycle"}, 32'(done_cyc), 32'(exp_cyc + stall_cyc));
      check({name, " done count"}, 32'(done_cnt), 32'h1);
      check({name, " busy at done"}, 32'(busy_at_done), 32'h1);
      check({name, " busy after done"}, 32'(busy_after), 32'h0);
      check({name, " detail count"}, 32'(got.size()), 32'(exp_det.size()));
      for (int k = 0; k < got.size() && k < exp_det.size(); k++)
        check($sformatf("%s det[%0d]", name, k), got[k], exp_det[k]);
      for (int k = 0; k < len; k++)
        check($sformatf("%s mem[%0d]", name, k), 32'(mem[k]), 32'(exp_mem[k]));
      if (stall_mode != 0) check({name, " stall freeze"}, 32'(bad_stall), 32'h0);
      if (stall_mode == 1) check({name, " stall cycles"}, 32'(stall_cyc), 32'(stall_n));
      if (lvls == 0) check({name, " no access"}, 32'(we_cnt + en_cnt), 32'h0);
    end
  endtask

  initial begin
    int lv_r;
    int len_r;
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_lvls = '0; det_ready = 1'b1; mem_init = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    preload(1'b0);
    run_job("len8 lv1", 8, 1, 0, 0, -1);
    check("len8 lv1 approx", {mem[0], mem[1]}, {16'd2, 16'd4});
    check("len8 lv1 approx hi", {mem[2], mem[3]}, {16'd6, 16'd8});

    preload(1'b0);
    run_job("len8 lv2", 8, 2, 0, 0, -1);
    check("len8 lv2 approx", {mem[0], mem[1]}, {16'd4, 16'd8});

    preload(1'b0);
    run_job("len8 stall", 8, 1, 1, 5, -1);

    preload(1'b0);
    run_job("len4 lv3", 4, 3, 0, 0, -1);
    check("len4 lv3 details", 32'(exp_det.size()), 32'd3);

    preload(1'b0);
    run_job("lv0", 8, 0, 0, 0, -1);

    preload(1'b0);
    run_job("start busy", 8, 2, 0, 0, 7);

    // Abandon a job mid-level, then rerun it from scratch.
    preload(1'b0);
    @(negedge clk);
    cfg_len = 11'd16; cfg_lvls = 3'd2; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (11) @(negedge clk);
    check("busy before rst", {31'b0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1 check_quiet("mid rst");
    @(negedge clk) rst = 1'b0;
    preload(1'b0);
    run_job("after rst", 16, 2, 0, 0, -1);

    for (int j = 0; j < 8; j++) begin
      lv_r = $urandom_range(4);
      len_r = $urandom_range(1, 4) << ((lv_r == 0) ? 1 : lv_r);
      preload(1'b1);
      run_job($sformatf("rnd%0d", j), len_r, lv_r, 2, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
